// File: rtl/twos_complement_sequencer.sv
// Bit-serial two's complement / pass-through unit. It walks the operand LSB-first,
// one bit per clock, copying bits up to and including the first 1 and inverting the rest.
module twos_complement_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] In_Data,
  input  logic             Mode,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Out_Data,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Overflow,
  output logic             Busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // In_Ready is high only in IDLE, and Out_Valid is high only in DONE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_one_q, seen_one_d;
  logic             mode_q, mode_d;
  logic             ovf_q, ovf_d;
  logic             cur_bit;
  logic             out_bit;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      seen_one_q <= 1'b0;
      mode_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      result_q   <= result_d;
      cnt_q      <= cnt_d;
      seen_one_q <= seen_one_d;
      mode_q     <= mode_d;
      ovf_q      <= ovf_d;
    end
  end

  assign cur_bit = shift_q[0];
  // This is the per-bit true/inverted select of a combinational complementer.
  assign out_bit = (mode_q & seen_one_q) ? ~cur_bit : cur_bit;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    result_d   = result_q;
    cnt_d      = cnt_q;
    seen_one_d = seen_one_q;
    mode_d     = mode_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (In_Valid) begin
          shift_d    = In_Data;
          result_d   = '0;
          cnt_d      = '0;
          seen_one_d = 1'b0;
          mode_d     = Mode;
          ovf_d      = Mode & (In_Data == MIN_NEG);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        shift_d    = shift_q >> 1;
        result_d   = {out_bit, result_q[WIDTH-1:1]};
        seen_one_d = seen_one_q | cur_bit;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        if (Out_Ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign In_Ready  = Rst_n & (state_q == IDLE);
  assign Out_Valid = (state_q == DONE);
  assign Out_Data  = (state_q == DONE) ? result_q : '0;
  assign Overflow  = (state_q == DONE) & ovf_q;
  assign Busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_twos_complement_sequencer.sv
// Bench for twos_complement_sequencer: directed cases plus random operands checked
// against an arithmetic negation model through an expected-result queue.
module tb_twos_complement_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;
  localparam int MOD   = 1 << WIDTH;

  logic             Clk;
  logic             Rst_n;
  logic [WIDTH-1:0] In_Data;
  logic             Mode;
  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] Out_Data;
  logic             Out_Valid;
  logic             Out_Ready;
  logic             Overflow;
  logic             Busy;
  logic [1:0]       dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_accept = 0;
  logic [WIDTH:0] exp_q[$];

  twos_complement_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_Data   (In_Data),
    .Mode      (Mode),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Out_Data  (Out_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Overflow  (Overflow),
    .Busy      (Busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // {overflow, result}: negation is plain modular subtraction from zero.
  function automatic logic [WIDTH:0] model(input int x, input bit m);
    int r;
    bit ovf;
    r   = m ? ((MOD - x) % MOD) : x;
    ovf = m && (x == MOD / 2);
    return {ovf, r[WIDTH-1:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Waits for Out_Valid; lat is the number of edges waited, 0 on timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= WIDTH + 6; k++) begin
      step();
      if (Out_Valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  // Sends one operand, checks latency/result, applies bp cycles of backpressure.
  task automatic do_op(input logic [WIDTH-1:0] x, input bit m, input int bp, input bit chk_space);
    int lat;
    logic [WIDTH:0] exp;
    Out_Ready = (bp == 0);
    In_Data   = x;
    Mode      = m;
    In_Valid  = 1'b1;
    check("in_ready_before_accept", In_Ready, 1);
    step();
    In_Valid = 1'b0;
    In_Data  = WIDTH'($urandom);
    Mode     = 1'($urandom);
    if (chk_space) check("spacing", cyc - last_accept, WIDTH + 2);
    last_accept = cyc;
    exp_q.push_back(model(int'(x), m));
    check("in_ready_low_busy", {In_Ready, Busy}, 2'b01);
    wait_valid(lat);
    check("latency", lat, WIDTH);
    exp = exp_q.pop_front();
    check("out_data", Out_Data, exp[WIDTH-1:0]);
    check("overflow", Overflow, exp[WIDTH]);
    for (int i = 0; i < bp; i++) begin
      step();
      check("bp_hold", {Out_Valid, In_Ready, Out_Data}, {2'b10, exp[WIDTH-1:0]});
    end
    Out_Ready = 1'b1;
    step();
    check("after_handshake", {Out_Valid, Overflow, In_Ready, Busy, Out_Data}, {4'b0010, {WIDTH{1'b0}}});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    Rst_n     = 1'b0;
    In_Data   = '0;
    Mode      = 1'b0;
    In_Valid  = 1'b0;
    Out_Ready = 1'b0;
    #12;
    check("reset_outputs", {In_Ready, Out_Valid, Overflow, Busy, Out_Data}, '0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    check("reset_release_ready", In_Ready, 1);
    step();
    check("idle_no_valid", {Busy, In_Ready}, 2'b01);

    // Basic negation, zero, most-negative, pass-through
    do_op(4'b0101, 1'b1, 0, 1'b0);
    do_op(4'b0000, 1'b1, 0, 1'b1);
    do_op(4'b1000, 1'b1, 0, 1'b1);
    do_op(4'b1010, 1'b0, 0, 1'b1);
    do_op(4'b1111, 1'b1, 0, 1'b1);

    // Backpressure with an operand offered during DONE
    Out_Ready = 1'b0;
    In_Data   = 4'b0011;
    Mode      = 1'b1;
    In_Valid  = 1'b1;
    step();
    In_Valid = 1'b0;
    wait_valid(lat);
    check("bp_latency", lat, WIDTH);
    In_Data  = 4'b0001;
    Mode     = 1'b1;
    In_Valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_stable", {Out_Valid, In_Ready, Out_Data}, {2'b10, 4'b1101});
    end
    Out_Ready = 1'b1;
    step();
    check("bp_release_not_accepted", {Busy, In_Ready, Out_Valid}, 3'b010);
    step();
    In_Valid = 1'b0;
    check("bp_next_accepted", {Busy, In_Ready}, 2'b10);
    wait_valid(lat);
    check("bp_next_latency", lat, WIDTH);
    check("bp_next_data", {Overflow, Out_Data}, {1'b0, 4'b1111});
    step();
    check("bp_next_done", Out_Valid, 0);

    // Reset in the middle of SHIFT
    In_Data  = 4'b0110;
    Mode     = 1'b1;
    In_Valid = 1'b1;
    step();
    In_Valid = 1'b0;
    step();
    step();
    #2;
    Rst_n = 1'b0;
    #1;
    check("mid_reset_async", {In_Ready, Out_Valid, Overflow, Busy, Out_Data}, '0);
    step();
    check("mid_reset_hold", {In_Ready, Busy, dbg_state}, 4'b0000);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    check("mid_reset_release", In_Ready, 1);
    for (int i = 0; i < WIDTH + 2; i++) begin
      step();
      check("no_aborted_valid", {Out_Valid, Busy}, 2'b00);
    end
    do_op(4'b0110, 1'b1, 0, 1'b0);

    // Exhaustive back-to-back sweep
    for (int m = 0; m < 2; m++)
      for (int x = 0; x < MOD; x++)
        do_op(x[WIDTH-1:0], m[0], 0, !(m == 0 && x == 0));

    // Random operands with random backpressure
    for (int i = 0; i < 30; i++)
      do_op(WIDTH'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b0);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/twos_complement_sequencer.md
Name: twos_complement_sequencer

Overview:
- Bit-serial controller that produces the two's complement of a WIDTH-bit operand, or passes the operand through unchanged.
- Accepts operands over a valid/ready input handshake. Walks the operand LSB-first, one bit per clock, using the "copy through first 1, invert thereafter" rule.
- Presents the result over a valid/ready output handshake.
- Per bit, it sequences the choice between the true and inverted bit, which is the per-bit select that the combinational complementer's 2:1 mux performs.

Parameters:
- WIDTH, 4, operand/result width in bits (minimum 2).
- CNT_W, 3, width of the bit counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- In_Data  input  WIDTH  operand.
- Mode  input  1  1 = negate (two's complement); 0 = pass-through. Sampled with In_Data.
- In_Valid  input  1  operand valid.
- In_Ready  output  1  block can accept an operand.
- Out_Data  output  WIDTH  result.
- Out_Valid  output  1  result valid.
- Out_Ready  input  1  consumer accepts result.
- Overflow  output  1  negation of the most-negative value (1 followed by zeros); qualified by Out_Valid.
- Busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (Rst_n low, asynchronous):
  - state=IDLE; shift register, result register, counter, Seen_One, Overflow, Out_Data, Out_Valid, Busy all 0.
  - In_Ready=1 while Rst_n is high and state=IDLE. In_Ready is 0 during reset.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - In_Ready=1.
  - On an edge with In_Valid=1, capture In_Data into the shift register, latch Mode, clear counter and Seen_One, then go to SHIFT.
  - In_Valid=0 stays in IDLE.
- SHIFT (exactly WIDTH cycles, one bit per edge):
  - b = shift_reg[0].
  - Output bit r = b if Mode=0, or if Mode=1 and Seen_One=0; r = ~b if Mode=1 and Seen_One=1.
  - Seen_One <= Seen_One | b.
  - r is shifted into the result MSB; the result register shifts right.
  - Counter increments. On the edge where counter = WIDTH-1, go to DONE.
- DONE:
  - Out_Valid=1; Out_Data holds the result stable until handshake.
  - Overflow = Mode & (operand == {1'b1, {WIDTH-1{1'b0}}}), computed from the captured operand.
  - On an edge with Out_Ready=1, go to IDLE, with Out_Valid=0 and Overflow=0 the next cycle.
  - Out_Ready=0 holds DONE indefinitely (backpressure). In_Ready stays 0 throughout.
- Latency:
  - Acceptance at edge E0; Out_Valid rises after edge E_WIDTH (WIDTH cycles later).
  - Minimum operand spacing is WIDTH+2 cycles (IDLE→SHIFT×WIDTH→DONE→IDLE).
- Single outstanding operation: no acceptance in SHIFT/DONE, so In_Valid is ignored there. No input buffering; the requester must hold In_Valid and In_Data until In_Ready.
- Arithmetic: the result is modulo 2^WIDTH.
  - Zero negates to zero, with Overflow=0.
  - The most-negative value negates to itself, with Overflow=1.
  - Mode=0 returns the operand bit-exact with Overflow=0.
- Simultaneous events:
  - Out_Ready held high before DONE has no effect.
  - In_Valid asserted on the same edge that DONE→IDLE completes is not accepted until the following IDLE edge.
- Reset mid-operation (SHIFT or DONE) aborts immediately:
  - Outputs return to reset values; the partial result is discarded and no Out_Valid is produced.
  - After release, the block is in IDLE with In_Ready=1.
- Out_Data is 0 outside DONE.

Test Plan:
1. Reset, then In_Data=4'b0101, Mode=1, In_Valid pulse → In_Ready drops next cycle; after 4 cycles Out_Valid=1, Out_Data=4'b1011, Overflow=0; with Out_Ready=1, Out_Valid falls next cycle.
2. In_Data=4'b0000 and 4'b1000 (Mode=1) in sequence → 4'b0000 with Overflow=0, then 4'b1000 with Overflow=1.
3. Mode=0, In_Data=4'b1010 → Out_Data=4'b1010, Overflow=0, same 4-cycle latency; then In_Data=4'b1111, Mode=1 → 4'b0001.
4. Backpressure: Out_Ready=0 for 10 cycles in DONE → Out_Valid and Out_Data=4'b1101 (from 4'b0011, Mode=1) stable throughout. A new In_Valid with In_Data=4'b0001 during DONE is not accepted. It is accepted in the first IDLE cycle after release, and its result is 4'b1111.
5. Reset mid-SHIFT: assert Rst_n=0 two cycles after accepting 4'b0110 → outputs zero asynchronously, In_Ready=0. After release, In_Ready=1, no Out_Valid from the aborted operand, and the next operand 4'b0110 yields 4'b1010.
6. Exhaustive sweep of all 16 operands × both modes, back-to-back with Out_Ready=1 → every result equals (Mode ? -x : x) mod 16, spacing exactly 6 cycles, and Overflow only for x=4'b1000 with Mode=1.
